cnn16_conv_sequencer: RTL and testbench

- Control FSM that runs a KxK, stride-1, valid-only 2D convolution on the cnn16 datapath.
- Generates the memory addresses and read/write strobes itself.
- Drives the datapath control lines bus_sel, alu_sel, AC_Load, DR_Load and TR_Load, one MAC step at a time.
- TR holds the running accumulator. AC and DR form the ALU operand pair.

---
 rtl/cnn16_conv_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_cnn16_conv_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn16_conv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cnn16_conv_sequencer : KxK stride-1 valid 2D convolution control FSM     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module cnn16_conv_sequencer #(
  parameter int         K         = 3,
  parameter int         ALU_LAT   = 1,
  parameter logic [3:0] ALU_ADD   = 4'h0,
  parameter logic [3:0] ALU_MUL   = 4'h2,
  parameter logic [3:0] ALU_PASSB = 4'hE,
  parameter logic [3:0] ALU_NOP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [11:0] img_base,
  input  logic [11:0] ker_base,
  input  logic [11:0] out_base,
  input  logic [7:0]  img_w,
  input  logic [7:0]  img_h,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [11:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [4:0]  bus_sel,
  output logic [3:0]  alu_sel,
  output logic        AC_Load,
  output logic        DR_Load,
  output logic        TR_Load
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CLR  = 4'd1,
    S_RDK  = 4'd2,
    S_LDK  = 4'd3,
    S_CPK  = 4'd4,
    S_LDP  = 4'd5,
    S_MUL  = 4'd6,
    S_LDA  = 4'd7,
    S_ADD  = 4'd8,
    S_STA  = 4'd9,
    S_WR   = 4'd10,
    S_FIN  = 4'd11
  } state_t;

  localparam logic [2:0]  c_kmax   = 3'(K - 1);
  localparam logic [7:0]  c_k8     = 8'(K);
  localparam logic [11:0] c_k12    = 12'(K);
  localparam logic [7:0]  c_latmax = 8'(ALU_LAT - 1);

  state_t      r_state, w_next;
  logic [11:0] r_img_base, r_ker_base, r_out_base, r_ocnt;
  logic [7:0]  r_img_w, r_img_h, r_ox, r_oy, r_lat;
  logic [2:0]  r_kx, r_ky;
  logic        r_err;
  logic        w_cfg_bad, w_last_tap, w_ox_end, w_last_out, w_lat_end;
  logic [11:0] w_row, w_pix_addr, w_ker_addr, w_out_addr;

  assign w_cfg_bad  = (img_w < c_k8) || (img_h < c_k8);
  assign w_last_tap = (r_kx == c_kmax) && (r_ky == c_kmax);
  assign w_ox_end   = (r_ox == r_img_w - c_k8);
  assign w_last_out = w_ox_end && (r_oy == r_img_h - c_k8);
  assign w_lat_end  = (r_lat == c_latmax);

  // All address arithmetic deliberately wraps at 12 bits.
  assign w_row      = {4'd0, r_oy} + {9'd0, r_ky};
  assign w_pix_addr = r_img_base + w_row * {4'd0, r_img_w} + {4'd0, r_ox} + {9'd0, r_kx};
  assign w_ker_addr = r_ker_base + {9'd0, r_ky} * c_k12 + {9'd0, r_kx};
  assign w_out_addr = r_out_base + r_ocnt;
  assign err        = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    mem_addr = 12'd0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    bus_sel  = 5'd31;
    alu_sel  = ALU_NOP;
    AC_Load  = 1'b0;
    DR_Load  = 1'b0;
    TR_Load  = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = w_cfg_bad ? S_FIN : S_CLR;
      S_CLR:  begin busy = 1'b1; TR_Load = 1'b1; w_next = S_RDK; end
      S_RDK:  begin busy = 1'b1; mem_addr = w_ker_addr; mem_re = 1'b1; w_next = S_LDK; end
      S_LDK:  begin busy = 1'b1; bus_sel = 5'd4; DR_Load = 1'b1; w_next = S_CPK; end
      S_CPK: begin
        busy     = 1'b1;
        alu_sel  = ALU_PASSB;
        AC_Load  = 1'b1;
        mem_addr = w_pix_addr;
        mem_re   = 1'b1;
        w_next   = S_LDP;
      end
      S_LDP:  begin busy = 1'b1; bus_sel = 5'd4; DR_Load = 1'b1; w_next = S_MUL; end
      S_MUL: begin
        busy    = 1'b1;
        alu_sel = ALU_MUL;
        AC_Load = w_lat_end;
        if (w_lat_end) w_next = S_LDA;
      end
      S_LDA:  begin busy = 1'b1; bus_sel = 5'd2; DR_Load = 1'b1; w_next = S_ADD; end
      S_ADD: begin
        busy    = 1'b1;
        alu_sel = ALU_ADD;
        AC_Load = w_lat_end;
        if (w_lat_end) w_next = S_STA;
      end
      S_STA: begin
        busy    = 1'b1;
        bus_sel = 5'd1;
        TR_Load = 1'b1;
        w_next  = w_last_tap ? S_WR : S_RDK;
      end
      S_WR: begin
        busy     = 1'b1;
        mem_addr = w_out_addr;
        bus_sel  = 5'd2;
        mem_we   = 1'b1;
        w_next   = w_last_out ? S_FIN : S_CLR;
      end
      S_FIN:   begin done = 1'b1; w_next = S_IDLE; end
      default: w_next = S_IDLE;
    endcase
    // Abort outranks every transition, including a start in IDLE.
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_img_base <= 12'd0;
      r_ker_base <= 12'd0;
      r_out_base <= 12'd0;
      r_img_w    <= 8'd0;
      r_img_h    <= 8'd0;
      r_err      <= 1'b0;
      r_ox       <= 8'd0;
      r_oy       <= 8'd0;
      r_kx       <= 3'd0;
      r_ky       <= 3'd0;
      r_ocnt     <= 12'd0;
      r_lat      <= 8'd0;
    end else if (abort) begin
      r_ox   <= 8'd0;
      r_oy   <= 8'd0;
      r_kx   <= 3'd0;
      r_ky   <= 3'd0;
      r_ocnt <= 12'd0;
      r_lat  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_img_base <= img_base;
          r_ker_base <= ker_base;
          r_out_base <= out_base;
          r_img_w    <= img_w;
          r_img_h    <= img_h;
          r_err      <= w_cfg_bad;
          r_ox       <= 8'd0;
          r_oy       <= 8'd0;
          r_kx       <= 3'd0;
          r_ky       <= 3'd0;
          r_ocnt     <= 12'd0;
          r_lat      <= 8'd0;
        end
        S_MUL, S_ADD: r_lat <= w_lat_end ? 8'd0 : r_lat + 8'd1;
        S_STA: begin
          if (r_kx == c_kmax) begin
            r_kx <= 3'd0;
            r_ky <= r_ky + 3'd1;
          end else begin
            r_kx <= r_kx + 3'd1;
          end
        end
        S_WR: begin
          r_kx   <= 3'd0;
          r_ky   <= 3'd0;
          r_ocnt <= r_ocnt + 12'd1;
          if (w_ox_end) begin
            r_ox <= 8'd0;
            r_oy <= r_oy + 8'd1;
          end else begin
            r_ox <= r_ox + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cnn16_conv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cnn16_conv_sequencer : scoreboard bench with datapath + memory model  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_cnn16_conv_sequencer;

  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_MUL   = 4'h2;
  localparam logic [3:0] ALU_PASSB = 4'hE;
  localparam logic [3:0] ALU_NOP   = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [11:0] img_base = 12'd0, ker_base = 12'd0, out_base = 12'd0;
  logic [7:0]  img_w = 8'd0, img_h = 8'd0;
  logic [1:0]  busy, done, err, mem_re, mem_we, ac_load, dr_load, tr_load;
  logic [11:0] mem_addr [2];
  logic [4:0]  bus_sel [2];
  logic [3:0]  alu_sel [2];

  // Instance 0 uses single-cycle ALU, instance 1 a three-cycle ALU.
  cnn16_conv_sequencer #(.K(3), .ALU_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort),
    .img_base(img_base), .ker_base(ker_base), .out_base(out_base),
    .img_w(img_w), .img_h(img_h), .busy(busy[0]), .done(done[0]), .err(err[0]),
    .mem_addr(mem_addr[0]), .mem_re(mem_re[0]), .mem_we(mem_we[0]),
    .bus_sel(bus_sel[0]), .alu_sel(alu_sel[0]),
    .AC_Load(ac_load[0]), .DR_Load(dr_load[0]), .TR_Load(tr_load[0]));

  cnn16_conv_sequencer #(.K(3), .ALU_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort),
    .img_base(img_base), .ker_base(ker_base), .out_base(out_base),
    .img_w(img_w), .img_h(img_h), .busy(busy[1]), .done(done[1]), .err(err[1]),
    .mem_addr(mem_addr[1]), .mem_re(mem_re[1]), .mem_we(mem_we[1]),
    .bus_sel(bus_sel[1]), .alu_sel(alu_sel[1]),
    .AC_Load(ac_load[1]), .DR_Load(dr_load[1]), .TR_Load(tr_load[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath and memory model
  logic [15:0] mem [4096];
  logic [15:0] ac [2], dr [2], tr [2], rd [2];

  function automatic logic [15:0] bus_f(input logic [4:0] sel, input logic [15:0] d, a, t, r);
    case (sel)
      5'd0:    return d;
      5'd1:    return a;
      5'd2:    return t;
      5'd4:    return r;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, b);
    case (op)
      ALU_ADD:   return a + b;
      ALU_MUL:   return a * b;
      ALU_PASSB: return b;
      default:   return a;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_re[i])  rd[i] <= mem[mem_addr[i]];
      if (ac_load[i]) ac[i] <= alu_f(alu_sel[i], ac[i], dr[i]);
      if (dr_load[i]) dr[i] <= bus_f(bus_sel[i], dr[i], ac[i], tr[i], rd[i]);
      if (tr_load[i]) tr[i] <= bus_f(bus_sel[i], dr[i], ac[i], tr[i], rd[i]);
    end
  end

  // Scoreboard
  int n_vec = 0;
  int n_miss = 0;
  logic [27:0] exp_wr [$];
  logic [11:0] exp_rd [$];
  bit trace_en = 1'b0;
  int rd_seen [2] = '{0, 0};
  int wr_seen [2] = '{0, 0};
  int done_seen [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [15:0] d);
    exp_wr.push_back({a, d});
  endtask

  always @(negedge clk) begin : mon
    logic [27:0] e;
    logic [11:0] ea;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        if (mem_re[i]) begin
          rd_seen[i]++;
          if (i == 0 && trace_en) begin
            if (exp_rd.size() == 0) begin
              n_vec++; n_miss++;
              $display("FAIL rd_trace: unexpected read at %03h", mem_addr[i]);
            end else begin
              ea = exp_rd.pop_front();
              check("rd_trace", 32'(mem_addr[i]), 32'(ea));
            end
          end
        end
        if (mem_we[i]) begin
          wr_seen[i]++;
          if (exp_wr.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL wr_unexpected: dut%0d wrote %0h to %03h", i,
                     bus_f(bus_sel[i], dr[i], ac[i], tr[i], rd[i]), mem_addr[i]);
          end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(mem_addr[i]), 32'(e[27:16]));
            check("wr_data", 32'(bus_f(bus_sel[i], dr[i], ac[i], tr[i], rd[i])), 32'(e[15:0]));
          end
        end
        if (done[i]) done_seen[i]++;
      end
    end
  end

  task automatic set_cfg(input logic [11:0] ib, kb, ob, input logic [7:0] w, h);
    img_base = ib; ker_base = kb; out_base = ob; img_w = w; img_h = h;
  endtask

  // Starts a job and waits for done; latency counts edges from the start edge
  // to the edge that captures done.
  task automatic run_job(input int inst, input string tag, input int exp_lat,
                         input logic exp_err, input int exp_writes, input int restart_at);
    int c0, lat, rd0, wr0, busy_bad;
    bit seen;
    rd0 = rd_seen[inst]; wr0 = wr_seen[inst];
    busy_bad = 0; seen = 1'b0; lat = 0;
    @(negedge clk); start[inst] = 1'b1;
    @(negedge clk); start[inst] = 1'b0; c0 = cyc;
    for (int k = 0; k < 3000 && !seen; k++) begin
      if (done[inst]) begin
        seen = 1'b1;
        lat  = cyc - c0 + 1;
      end else begin
        if (busy[inst] !== 1'b1) busy_bad++;
        start[inst] = (k == restart_at);
        @(negedge clk);
      end
    end
    start[inst] = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(err[inst]), 32'(exp_err));
    check({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done[inst]), 32'd0);
    check({tag, "_busy_after"}, 32'(busy[inst]), 32'd0);
    check({tag, "_write_count"}, 32'(wr_seen[inst] - wr0), 32'(exp_writes));
    check({tag, "_wr_queue_left"}, 32'(exp_wr.size()), 32'd0);
    if (exp_err) check({tag, "_reads"}, 32'(rd_seen[inst] - rd0), 32'd0);
  endtask

  task automatic check_idle(input int inst, input string tag);
    check({tag, "_busy"}, 32'(busy[inst]), 32'd0);
    check({tag, "_done"}, 32'(done[inst]), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr[inst]), 32'd0);
    check({tag, "_strobes"}, 32'({mem_re[inst], mem_we[inst]}), 32'd0);
    check({tag, "_loads"}, 32'({ac_load[inst], dr_load[inst], tr_load[inst]}), 32'd0);
    check({tag, "_bus_sel"}, 32'(bus_sel[inst]), 32'd31);
    check({tag, "_alu_sel"}, 32'(alu_sel[inst]), 32'(ALU_NOP));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, w0;
    bit found;
    for (int a = 0; a < 4096; a++) mem[a] = 16'd0;
    for (int a = 0; a < 16; a++) mem[12'h100 + 12'(a)] = 16'd1;
    for (int a = 0; a < 9; a++) begin
      mem[12'h080 + 12'(a)] = 16'd1;
      mem[12'h300 + 12'(a)] = 16'(a);
    end
    mem[12'h384] = 16'd1;
    for (int a = 0; a < 15; a++) mem[12'h500 + 12'(a)] = 16'(a);

    repeat (3) @(negedge clk);
    check_idle(0, "reset0");
    check_idle(1, "reset1");
    check("reset_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 4x4 ones * 3x3 ones, with full read-address trace
    set_cfg(12'h100, 12'h080, 12'h200, 8'd4, 8'd4);
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            exp_rd.push_back(12'(32'h080 + ky * 3 + kx));
            exp_rd.push_back(12'(32'h100 + (oy + ky) * 4 + ox + kx));
          end
    for (int o = 0; o < 4; o++) push_wr(12'h200 + 12'(o), 16'd9);
    trace_en = 1'b1;
    run_job(0, "jobA", 297, 1'b0, 4, -1);
    trace_en = 1'b0;
    check("jobA_rd_trace_left", 32'(exp_rd.size()), 32'd0);

    // Image narrower than the kernel
    set_cfg(12'h100, 12'h080, 12'h200, 8'd2, 8'd5);
    run_job(0, "jobErr", 1, 1'b1, 0, -1);

    // 5x3 index image * ones: outputs 54, 63, 72; err clears on this start
    set_cfg(12'h500, 12'h080, 12'h600, 8'd5, 8'd3);
    push_wr(12'h600, 16'd54); push_wr(12'h601, 16'd63); push_wr(12'h602, 16'd72);
    run_job(0, "jobC", 3 * 74 + 1, 1'b0, 3, -1);

    // ALU_LAT=3, identity-centre kernel over 0..8 -> single write of 4
    set_cfg(12'h300, 12'h380, 12'h400, 8'd3, 8'd3);
    push_wr(12'h400, 16'd4);
    run_job(1, "jobLat3", 2 + 9 * 12 + 1, 1'b0, 1, -1);

    // Abort during the fifth tap's MUL
    set_cfg(12'h100, 12'h080, 12'h200, 8'd4, 8'd4);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    n = 0; found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (alu_sel[0] == ALU_MUL) begin
        n++;
        found = (n == 5);
      end
      if (!found) @(negedge clk);
    end
    check("abort_reached_mul5", 32'(found), 32'd1);
    d0 = done_seen[0]; w0 = wr_seen[0];
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_idle(0, "abort");
    repeat (400) @(negedge clk);
    check("abort_no_done", 32'(done_seen[0] - d0), 32'd0);
    check("abort_no_write", 32'(wr_seen[0] - w0), 32'd0);
    check("abort_err", 32'(err[0]), 32'd0);
    for (int o = 0; o < 4; o++) push_wr(12'h200 + 12'(o), 16'd9);
    run_job(0, "jobAfterAbort", 297, 1'b0, 4, -1);

    // Abort and start together in IDLE
    @(negedge clk); start[0] = 1'b1; abort = 1'b1;
    @(negedge clk); start[0] = 1'b0; abort = 1'b0;
    check("abort_start_busy", 32'(busy[0]), 32'd0);
    check("abort_start_done", 32'(done[0]), 32'd0);

    // Asynchronous reset while in LDA
    set_cfg(12'h500, 12'h080, 12'h600, 8'd5, 8'd3);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      found = (bus_sel[0] == 5'd2) && dr_load[0];
      if (!found) @(negedge clk);
    end
    check("rst_reached_lda", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1 check_idle(0, "async_rst");
    @(negedge clk); rst = 1'b1;
    push_wr(12'h600, 16'd54); push_wr(12'h601, 16'd63); push_wr(12'h602, 16'd72);
    run_job(0, "jobAfterRst", 3 * 74 + 1, 1'b0, 3, -1);

    // start pulsed mid-job is ignored
    set_cfg(12'h100, 12'h080, 12'h200, 8'd4, 8'd4);
    for (int o = 0; o < 4; o++) push_wr(12'h200 + 12'(o), 16'd9);
    run_job(0, "jobRestart", 297, 1'b0, 4, 100);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
